// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the slave front-end state type for the AHB-APB bridge.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_REQ,
    ST_RESP,
    ST_ERR1,
    ST_ERR2
  } state_e;

endpackage

// File: rtl/ahb_xfer_check.sv
// Address-phase decode for a bridge slave: window select and size/alignment legality.
module ahb_xfer_check
  import ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter logic [31:0] ADDR_SPAN = 32'h0000_1000
) (
  input  logic [31:0] haddr_i,
  input  logic [2:0]  hsize_i,
  input  logic [1:0]  htrans_i,
  input  logic        hreadyin_i,
  output logic        sel_o,
  output logic        legal_o
);

  // One extra bit so a window ending at the top of the address map does not wrap.
  logic [32:0] end_addr;
  logic        in_window;
  logic        active;

  assign end_addr  = {1'b0, BASE_ADDR} + {1'b0, ADDR_SPAN};
  assign in_window = (haddr_i >= BASE_ADDR) && ({1'b0, haddr_i} < end_addr);
  assign active    = (htrans_i == HTRANS_NONSEQ) || (htrans_i == HTRANS_SEQ);
  assign sel_o     = hreadyin_i & active & in_window;

  always_comb begin
    legal_o = 1'b0;
    case (hsize_i)
      HSIZE_BYTE: legal_o = 1'b1;
      HSIZE_HALF: legal_o = ~haddr_i[0];
      HSIZE_WORD: legal_o = (haddr_i[1:0] == 2'b00);
      default:    legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/ahb_slave_if.sv
// AHB-Lite slave front end of the AHB-APB bridge: turns accepted transfers into
// req/ack requests and stretches the data phase until the downstream side answers.
//
// state | meaning
// IDLE  | ready, OKAY, waiting for a selected transfer
// DATA  | first data-phase cycle, write data captured at its end
// REQ   | request presented downstream until req_ack
// RESP  | one-cycle OKAY completion, may accept the next transfer
// ERR1  | first ERROR cycle, Hreadyout low
// ERR2  | second ERROR cycle, Hreadyout high, may accept the next transfer
module ahb_slave_if
  import ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter logic [31:0] ADDR_SPAN = 32'h0000_1000
) (
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic        Hwrite,
  input  logic        Hreadyin,
  input  logic [1:0]  Htrans,
  input  logic [2:0]  Hsize,
  input  logic [31:0] Haddr,
  input  logic [31:0] Hwdata,
  output logic        Hreadyout,
  output logic [1:0]  Hresp,
  output logic [31:0] Hrdata,
  output logic        req_valid,
  output logic        req_write,
  output logic [31:0] req_addr,
  output logic [31:0] req_wdata,
  input  logic        req_ack,
  input  logic        req_err,
  input  logic [31:0] req_rdata
);

  state_e      state_q, state_d;
  logic        sel;
  logic        legal;
  logic        accept;
  logic [31:0] addr_q;
  logic        write_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;

  ahb_xfer_check #(
    .BASE_ADDR(BASE_ADDR),
    .ADDR_SPAN(ADDR_SPAN)
  ) u_xfer_check (
    .haddr_i   (Haddr),
    .hsize_i   (Hsize),
    .htrans_i  (Htrans),
    .hreadyin_i(Hreadyin),
    .sel_o     (sel),
    .legal_o   (legal)
  );

  always_comb begin
    state_d   = state_q;
    Hreadyout = 1'b1;
    Hresp     = HRESP_OKAY;
    req_valid = 1'b0;
    accept    = 1'b0;
    case (state_q)
      ST_IDLE, ST_RESP, ST_ERR2: begin
        if (state_q == ST_ERR2) Hresp = HRESP_ERROR;
        accept = sel;
        if (sel) state_d = legal ? ST_DATA : ST_ERR1;
        else     state_d = ST_IDLE;
      end
      ST_DATA: begin
        Hreadyout = 1'b0;
        state_d   = ST_REQ;
      end
      ST_REQ: begin
        Hreadyout = 1'b0;
        req_valid = 1'b1;
        if (req_ack) state_d = req_err ? ST_ERR1 : ST_RESP;
      end
      ST_ERR1: begin
        Hreadyout = 1'b0;
        Hresp     = HRESP_ERROR;
        state_d   = ST_ERR2;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept && legal) begin
        addr_q  <= Haddr;
        write_q <= Hwrite;
      end
      if (state_q == ST_DATA) wdata_q <= Hwdata;
      // Read data only on a clean read completion; errors and writes leave it alone.
      if (state_q == ST_REQ && req_ack && !req_err && !write_q) rdata_q <= req_rdata;
    end
  end

  assign req_addr  = addr_q;
  assign req_write = write_q;
  assign req_wdata = wdata_q;
  assign Hrdata    = rdata_q;

endmodule
